// File: rtl/wb_data_arbiter_pkg.sv
// Shared constants, FSM state encoding and index helper for the wb_data_arbiter slice.
// The optional timeout/error feature is enabled with the ARB_TIMEOUT_EN macro.
package wb_data_arbiter_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int DEFAULT_NUM_M   = 4;
  localparam int DEFAULT_TIMEOUT = 15;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/wb_data_arbiter_if.sv
// Bus bundle between the J1 masters, the arbiter and the shared data RAM.
// m_err_o exists only when ARB_TIMEOUT_EN is defined.
interface wb_data_arbiter_if #(
  parameter int NUM_M = 4
);
  import wb_data_arbiter_pkg::*;

  logic [NUM_M-1:0]            m_cyc_i;
  logic [NUM_M-1:0]            m_we_i;
  logic [NUM_M*DATA_WIDTH-1:0] m_adr_i;
  logic [NUM_M*DATA_WIDTH-1:0] m_dat_i;
  logic [DATA_WIDTH-1:0]       m_dat_o;
  logic [NUM_M-1:0]            m_ack_o;
  logic                        s_cyc_o;
  logic                        s_we_o;
  logic [DATA_WIDTH-1:0]       s_adr_o;
  logic [DATA_WIDTH-1:0]       s_dat_o;
  logic [DATA_WIDTH-1:0]       s_dat_i;
  logic                        s_ack_i;
  logic [NUM_M-1:0]            grant_o;
`ifdef ARB_TIMEOUT_EN
  logic [NUM_M-1:0]            m_err_o;
`endif

  // arbiter side
  modport slave (
    input  m_cyc_i, m_we_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, s_cyc_o, s_we_o, s_adr_o, s_dat_o, grant_o
`ifdef ARB_TIMEOUT_EN
    , output m_err_o
`endif
  );

  // environment side: masters plus RAM
  modport master (
    output m_cyc_i, m_we_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, s_cyc_o, s_we_o, s_adr_o, s_dat_o, grant_o
`ifdef ARB_TIMEOUT_EN
    , input m_err_o
`endif
  );

endinterface

// File: rtl/wb_data_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit of req searching upward from rr,
// wrapping modulo NUM_M.
module wb_data_arbiter_rr_pick #(
  parameter int NUM_M = 4,
  parameter int IDX_W = 2
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IDX_W-1:0] rr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_M; i++) begin
      cand = IDX_W'((int'(rr) + i) % NUM_M);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/wb_data_arbiter.sv
// Round-robin arbiter giving NUM_M J1 masters access to one data RAM slave.
// Define ARB_TIMEOUT_EN to add the BUSY watchdog and the m_err_o pulse.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ARB_IDLE | no grant; picks the next requester from rr upward
// ARB_BUSY | master gidx owns the slave until ack, abort or timeout
module wb_data_arbiter
  import wb_data_arbiter_pkg::*;
#(
  parameter int NUM_M   = DEFAULT_NUM_M,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  wb_data_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  arb_state_e       state;
  logic [IDX_W-1:0] gidx;
  logic [IDX_W-1:0] rr;
  logic [NUM_M-1:0] grant;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic [IDX_W-1:0] gidx_next;
  logic             busy;
  logic             cur_cyc;
  logic             done;
  logic             leave;

  wb_data_arbiter_rr_pick #(
    .NUM_M (NUM_M),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (bus.m_cyc_i),
    .rr    (rr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign busy      = (state == ARB_BUSY);
  assign cur_cyc   = bus.m_cyc_i[gidx];
  assign gidx_next = IDX_W'(next_idx(int'(gidx), NUM_M));
  // ack wins over a simultaneous abort: both end the transaction the same way
  assign done      = busy & (bus.s_ack_i | ~cur_cyc);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       tmo;

  // down-counter loaded on BUSY entry; terminal count marks BUSY cycle TIMEOUT
  assign tmo   = busy & ~done & (tmo_cnt == 8'd0);
  assign leave = done | tmo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= 8'd0;
    end else if (!busy && pick_valid) begin
      tmo_cnt <= 8'(TIMEOUT - 1);
    end else if (busy && tmo_cnt != 8'd0) begin
      tmo_cnt <= tmo_cnt - 8'd1;
    end
  end

  always_comb begin
    bus.m_err_o = '0;
    if (tmo) bus.m_err_o[gidx] = 1'b1;
  end
`else
  assign leave = done;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
      gidx  <= '0;
      rr    <= '0;
      grant <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            state <= ARB_BUSY;
            gidx  <= pick_idx;
            grant <= NUM_M'(1) << pick_idx;
          end
        end
        ARB_BUSY: begin
          if (leave) begin
            state <= ARB_IDLE;
            rr    <= gidx_next;
            grant <= '0;
          end
        end
        default: begin
          state <= ARB_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.s_we_o  = 1'b0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.m_ack_o = '0;
    if (busy) begin
      for (int i = 0; i < NUM_M; i++) begin
        if (gidx == IDX_W'(i)) begin
          bus.s_we_o  = bus.m_we_i[i];
          bus.s_adr_o = bus.m_adr_i[i*DATA_WIDTH +: DATA_WIDTH];
          bus.s_dat_o = bus.m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      bus.m_ack_o[gidx] = bus.s_ack_i;
    end
  end

  assign bus.s_cyc_o = busy & cur_cyc;
  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.grant_o = grant;

endmodule

// File: tb/tb_wb_data_arbiter.sv
// Directed bench for wb_data_arbiter: per-cycle vector table plus reset and timeout sequences.
module tb_wb_data_arbiter;

  localparam int NUM_M = 4;

  typedef struct {
    logic [3:0] cyc;
    logic [3:0] we;
    logic       ack;
    logic [3:0] grant;
    logic       scyc;
    logic [3:0] mack;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs[$];

  logic [31:0] adr_tab[4];
  logic [31:0] dat_tab[4];

  wb_data_arbiter_if #(.NUM_M(NUM_M)) bus ();

  wb_data_arbiter #(.NUM_M(NUM_M), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] cyc, input logic [3:0] we, input logic ack,
                     input logic [3:0] grant, input logic scyc, input logic [3:0] mack);
    vec_t v;
    v.cyc = cyc; v.we = we; v.ack = ack; v.grant = grant; v.scyc = scyc; v.mack = mack;
    vecs.push_back(v);
  endtask

  function automatic int gidx_of(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return -1;
  endfunction

  initial begin
    int   gx;
    logic [31:0] exp_adr, exp_dat;
    logic exp_we;

    checks = 0;
    errors = 0;
    adr_tab = '{32'h0000_1000, 32'h0000_2000, 32'h0000_1004, 32'h0000_3000};
    dat_tab = '{32'h1111_1111, 32'h2222_2222, 32'hDEAD_BEEF, 32'h4444_4444};

    rst = 1'b0;
    bus.m_cyc_i = '0;
    bus.m_we_i  = '0;
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = '0;
    for (int i = 0; i < 4; i++) begin
      bus.m_adr_i[i*32 +: 32] = adr_tab[i];
      bus.m_dat_i[i*32 +: 32] = dat_tab[i];
    end

    //   cyc      we       ack   grant    scyc  mack
    add(4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000); // 0  master 0 request seen in IDLE
    add(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 4'b0000);
    add(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 4'b0000);
    add(4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 4'b0001); // ack 2 cycles after s_cyc_o
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000);
    add(4'b0100, 4'b0100, 1'b0, 4'b0000, 1'b0, 4'b0000); // 5  master 2 write
    add(4'b0110, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0000); //    master 1 waits
    add(4'b0110, 4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0100);
    add(4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000); //    rr=3 -> master 1
    add(4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0010);
    add(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000); // 10 ack in IDLE is ignored
    add(4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000); //    master 3 abort
    add(4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b1, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b0, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000);
    add(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000); // 15 all request, rr=0
    add(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 4'b0001);
    add(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000);
    add(4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0010);
    add(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000);
    add(4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 4'b0100); // 20
    add(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000);
    add(4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 4'b1000);
    add(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000); //    wrap back to 0
    add(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 4'b0001);
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000); // 25
    add(4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000); //    ack together with abort
    add(4'b0000, 4'b0000, 1'b1, 4'b0100, 1'b0, 4'b0100);
    add(4'b1001, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000); //    rr=3 -> master 3 first
    add(4'b1001, 4'b0000, 1'b1, 4'b1000, 1'b1, 4'b1000);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", -1, 32'(bus.grant_o), 32'h0);
    chk("rst_scyc",  -1, 32'(bus.s_cyc_o), 32'h0);
    chk("rst_mack",  -1, 32'(bus.m_ack_o), 32'h0);
    chk("rst_sadr",  -1, bus.s_adr_o,      32'h0);
    rst = 1'b1;

    for (int r = 0; r < vecs.size(); r++) begin
      @(posedge clk);
      #1;
      bus.m_cyc_i = vecs[r].cyc;
      bus.m_we_i  = vecs[r].we;
      bus.s_ack_i = vecs[r].ack;
      bus.s_dat_i = 32'hA500_0000 | 32'(r);
      @(negedge clk);
      gx = gidx_of(vecs[r].grant);
      exp_adr = (gx < 0) ? 32'h0 : adr_tab[gx];
      exp_dat = (gx < 0) ? 32'h0 : dat_tab[gx];
      exp_we  = (gx < 0) ? 1'b0  : vecs[r].we[gx];
      chk("grant", r, 32'(bus.grant_o), 32'(vecs[r].grant));
      chk("s_cyc", r, 32'(bus.s_cyc_o), 32'(vecs[r].scyc));
      chk("m_ack", r, 32'(bus.m_ack_o), 32'(vecs[r].mack));
      chk("s_we",  r, 32'(bus.s_we_o),  32'(exp_we));
      chk("s_adr", r, bus.s_adr_o, exp_adr);
      chk("s_dat", r, bus.s_dat_o, exp_dat);
      chk("m_dat", r, bus.m_dat_o, 32'hA500_0000 | 32'(r));
    end

    // reset in the middle of a master 3 transaction, master 2 also waiting
    @(posedge clk);
    #1;
    bus.m_cyc_i = 4'b1000;
    bus.m_we_i  = 4'b0000;
    bus.s_ack_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_idle", 100, 32'(bus.grant_o), 32'h0);
    @(posedge clk);
    #1;
    bus.m_cyc_i = 4'b1100;
    @(negedge clk);
    chk("pre_rst_grant", 101, 32'(bus.grant_o), 32'h8);
    chk("pre_rst_scyc",  101, 32'(bus.s_cyc_o), 32'h1);
    #2;
    rst = 1'b0;
    bus.s_ack_i = 1'b1;
    #1;
    chk("mid_rst_grant", 102, 32'(bus.grant_o), 32'h0);
    chk("mid_rst_scyc",  102, 32'(bus.s_cyc_o), 32'h0);
    chk("mid_rst_mack",  102, 32'(bus.m_ack_o), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_mack",  103, 32'(bus.m_ack_o), 32'h0);
    chk("post_rst_grant", 103, 32'(bus.grant_o), 32'h0);
    @(posedge clk);
    #1;
    bus.s_ack_i = 1'b0;
    @(negedge clk);
    chk("post_rst_pick", 104, 32'(bus.grant_o), 32'h4);
    chk("post_rst_sadr", 104, bus.s_adr_o, 32'h0000_1004);
    @(posedge clk);
    #1;
    bus.s_ack_i = 1'b1;
    @(negedge clk);
    chk("post_rst_ack", 105, 32'(bus.m_ack_o), 32'h4);
    @(posedge clk);
    #1;
    bus.s_ack_i = 1'b0;
    bus.m_cyc_i = 4'b0000;

`ifdef ARB_TIMEOUT_EN
    // rr=3 here, so masters 0 and 1 requesting grant 0 first; slave never acks
    @(posedge clk);
    #1;
    bus.m_cyc_i = 4'b0011;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 1)  chk("tmo_grant", 200, 32'(bus.grant_o), 32'h1);
      if (c == 14) chk("tmo_err_early", 200 + c, 32'(bus.m_err_o), 32'h0);
      if (c == 15) chk("tmo_err", 200 + c, 32'(bus.m_err_o), 32'h1);
    end
    @(posedge clk);
    @(negedge clk);
    chk("tmo_idle", 216, 32'(bus.grant_o), 32'h0);
    chk("tmo_err_clear", 216, 32'(bus.m_err_o), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("tmo_next_grant", 217, 32'(bus.grant_o), 32'h2);
    #1;
    bus.m_cyc_i = 4'b0000;
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
